// File: rtl/regfile_pkg.sv
// Shared constants, FSM state type and round-robin helper for the
// register-file write arbiter.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        STALLED = 2'd2
    } arb_state_t;

    // Next index in round-robin order: idx+1, wrapping from n_req-1 to 0.
    function automatic logic [7:0] rr_next(input logic [7:0] idx, input logic [7:0] n_req);
        rr_next = (idx == n_req - 8'd1) ? 8'd0 : idx + 8'd1;
    endfunction

endpackage

// File: rtl/decoder_5to32.sv
// 5-to-32 one-hot decoder with enable; output is all zero when disabled.
module decoder_5to32
    import regfile_pkg::*;
(
    input  logic [4:0]          i_addr,
    input  logic                i_en,
    output logic [NUM_REGS-1:0] o_sel
);

    // Set exactly the addressed bit when enabled.
    always_comb begin
        o_sel = '0;
        if (i_en) begin
            o_sel[i_addr] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester after
// i_last_grant, searching upward and wrapping modulo N_REQ.
module rr_pick
    import regfile_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int GID_W = 2
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [GID_W-1:0] i_last_grant,
    output logic [N_REQ-1:0] o_grant,
    output logic [GID_W-1:0] o_gid,
    output logic             o_any
);

    // Walk the N_REQ candidates in priority order and keep the first hit.
    always_comb begin
        logic [7:0] w_cand;
        logic       w_found;
        o_grant = '0;
        o_gid   = '0;
        w_cand  = 8'(i_last_grant);
        w_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = rr_next(w_cand, 8'(N_REQ));
            if (!w_found && i_valid[w_cand[GID_W-1:0]]) begin
                w_found                    = 1'b1;
                o_gid                      = w_cand[GID_W-1:0];
                o_grant[w_cand[GID_W-1:0]] = 1'b1;
            end
        end
    end

    assign o_any = |i_valid;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among N_REQ
// requesters, followed by a one-cycle write stage.
//
// Handshake: requester k transfers in a cycle where i_req_valid[k] and
// o_req_ready[k] are both high. o_req_ready is combinational, at most one
// bit set, and all zero while i_stall is high or the FSM is STALLED.
// A requester may change addr/data freely except in the transfer cycle.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int CNT_W  = 8,
    localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int NSEL  = 2 ** ADDR_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_req_valid,
    input  logic [N_REQ*ADDR_W-1:0]   i_req_addr,
    input  logic [N_REQ*DATA_W-1:0]   i_req_data,
    output logic [N_REQ-1:0]          o_req_ready,
    input  logic                      i_stall,
    input  logic                      i_cnt_clr,
    output logic                      o_wr_en,
    output logic [NSEL-1:0]           o_wr_sel,
    output logic [ADDR_W-1:0]         o_wr_addr,
    output logic [DATA_W-1:0]         o_wr_data,
    output logic [GID_W-1:0]          o_wr_src,
    output logic                      o_busy,
    output logic [CNT_W-1:0]          o_wr_count
);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [GID_W-1:0]   r_last_grant;
    logic [N_REQ-1:0]   w_grant;
    logic [GID_W-1:0]   w_gid;
    logic               w_any;
    logic               w_block;
    logic               w_xfer;
    logic               w_issue;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic [GID_W-1:0]   r_wr_src;
    logic [CNT_W-1:0]   r_wr_count;

    rr_pick #(
        .N_REQ (N_REQ),
        .GID_W (GID_W)
    ) u_pick (
        .i_valid      (i_req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_gid        (w_gid),
        .o_any        (w_any)
    );

    // Live stall and the registered STALLED state both block acceptance;
    // the latter gives one bubble after a stall is released.
    assign w_block     = i_stall | (r_state == STALLED);
    assign o_req_ready = w_block ? '0 : w_grant;
    assign w_xfer      = |o_req_ready;
    // r0 is hardwired zero, so a write to it is accepted but never issued.
    assign w_issue     = w_xfer & (w_sel_addr != '0);

    // One-hot AND-OR mux steering the winner's address and data.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_grant[k]) begin
                w_sel_addr |= i_req_addr[k*ADDR_W +: ADDR_W];
                w_sel_data |= i_req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: stall dominates, STALLED always exits through IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (i_stall)    w_state_nxt = STALLED;
                else if (w_any) w_state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (i_stall)     w_state_nxt = STALLED;
                else if (!w_any) w_state_nxt = IDLE;
            end
            STALLED: begin
                if (!i_stall)    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Round-robin pointer moves to the winner only on a transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= GID_W'(N_REQ - 1);
        end else if (w_xfer) begin
            r_last_grant <= w_gid;
        end
    end

    // Write stage: capture the accepted write; strobe only for non-r0 targets.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_src  <= '0;
        end else begin
            r_wr_en <= w_issue;
            if (w_xfer) begin
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
                r_wr_src  <= w_gid;
            end
        end
    end

    // Saturating count of issued writes, updated together with the write stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_count <= '0;
        end else if (i_cnt_clr) begin
            r_wr_count <= '0;
        end else if (w_issue && (r_wr_count != {CNT_W{1'b1}})) begin
            r_wr_count <= r_wr_count + 1'b1;
        end
    end

    generate
        if (ADDR_W == 5) begin : g_dec
            decoder_5to32 u_dec (
                .i_addr (r_wr_addr),
                .i_en   (r_wr_en),
                .o_sel  (o_wr_sel)
            );
        end else begin : g_shift
            assign o_wr_sel = r_wr_en ? (NSEL'(1) << r_wr_addr) : '0;
        end
    endgenerate

    assign o_wr_en    = r_wr_en;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_wr_src   = r_wr_src;
    assign o_busy     = (r_state == ACTIVE);
    assign o_wr_count = r_wr_count;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed table, hand-written corner
// sequences and randomized traffic against a behavioural model.
module tb_regfile_wr_arbiter;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;
    localparam int GID_W  = 2;
    localparam int NSEL   = 32;
    localparam int SB_W   = GID_W + ADDR_W + DATA_W;
    localparam int N_VEC  = 14;

    logic                    i_clk;
    logic                    i_rst_n;
    logic [N_REQ-1:0]        i_req_valid;
    logic [N_REQ*ADDR_W-1:0] i_req_addr;
    logic [N_REQ*DATA_W-1:0] i_req_data;
    logic [N_REQ-1:0]        o_req_ready;
    logic                    i_stall;
    logic                    i_cnt_clr;
    logic                    o_wr_en;
    logic [NSEL-1:0]         o_wr_sel;
    logic [ADDR_W-1:0]       o_wr_addr;
    logic [DATA_W-1:0]       o_wr_data;
    logic [GID_W-1:0]        o_wr_src;
    logic                    o_busy;
    logic [CNT_W-1:0]        o_wr_count;

    regfile_wr_arbiter #(
        .N_REQ  (N_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .i_req_addr  (i_req_addr),
        .i_req_data  (i_req_data),
        .o_req_ready (o_req_ready),
        .i_stall     (i_stall),
        .i_cnt_clr   (i_cnt_clr),
        .o_wr_en     (o_wr_en),
        .o_wr_sel    (o_wr_sel),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_wr_src    (o_wr_src),
        .o_busy      (o_busy),
        .o_wr_count  (o_wr_count)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- bookkeeping ----------------
    int n_checks;
    int n_pass;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Behaviour expressed from the rules: acceptance is blocked by a stall
    // this cycle or last cycle; the winner is the first valid after the last
    // winner; r0 writes are swallowed; the counter saturates at 255.
    int              m_last;
    bit              m_prev_stall;
    bit              m_wr_en;
    int              m_addr;
    logic [31:0]     m_data;
    int              m_src;
    int              m_cnt;
    bit              m_busy;
    logic [SB_W-1:0] exp_q[$];

    task automatic model_reset();
        m_last       = N_REQ - 1;
        m_prev_stall = 1'b0;
        m_wr_en      = 1'b0;
        m_addr       = 0;
        m_data       = '0;
        m_src        = 0;
        m_cnt        = 0;
        m_busy       = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        i_req_addr[k*ADDR_W +: ADDR_W] = a;
        i_req_data[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic apply_reset();
        i_rst_n     = 1'b0;
        i_req_valid = '0;
        i_req_addr  = '0;
        i_req_data  = '0;
        i_stall     = 1'b0;
        i_cnt_clr   = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        model_reset();
    endtask

    // One clock: check ready at the negedge against the model (and an
    // optional hand-written value), advance the model, then check the
    // registered outputs 1 time unit after the rising edge.
    task automatic do_cycle(input logic [N_REQ-1:0] hand_rdy, input bit use_hand);
        int                win;
        int                idx;
        bit                blocked;
        logic [N_REQ-1:0]  exp_rdy;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [NSEL-1:0]   exp_sel;
        logic [SB_W-1:0]   e;
        @(negedge i_clk);
        win     = -1;
        blocked = i_stall || m_prev_stall;
        if (!blocked) begin
            for (int k = 1; k <= N_REQ; k++) begin
                idx = (m_last + k) % N_REQ;
                if (win < 0 && i_req_valid[idx]) win = idx;
            end
        end
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("ready_model", o_req_ready, exp_rdy);
        if (use_hand) chk("ready_table", o_req_ready, hand_rdy);

        m_busy       = !i_stall && (|i_req_valid) && !m_prev_stall;
        m_prev_stall = i_stall;
        if (win >= 0) begin
            a       = i_req_addr[win*ADDR_W +: ADDR_W];
            d       = i_req_data[win*DATA_W +: DATA_W];
            m_last  = win;
            m_addr  = a;
            m_data  = d;
            m_src   = win;
            m_wr_en = (a != 0);
            if (a != 0) exp_q.push_back({GID_W'(win), a, d});
        end else begin
            m_wr_en = 1'b0;
        end
        if (i_cnt_clr) m_cnt = 0;
        else if (m_wr_en && m_cnt < 255) m_cnt++;

        @(posedge i_clk);
        #1;
        exp_sel = m_wr_en ? (NSEL'(1) << m_addr) : '0;
        chk("wr_en", o_wr_en, m_wr_en);
        chk("wr_sel", o_wr_sel, exp_sel);
        chk("wr_addr", o_wr_addr, m_addr);
        chk("wr_data", o_wr_data, m_data);
        chk("wr_src", o_wr_src, m_src);
        chk("wr_count", o_wr_count, m_cnt);
        chk("busy", o_busy, m_busy);
        // scoreboard: every strobed write must be the next expected one
        if (o_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_write", {o_wr_src, o_wr_addr, o_wr_data}, e);
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit               do_reset;
        logic [N_REQ-1:0] valid;
        bit               stall;
        logic [N_REQ-1:0] exp_ready;
    } vec_t;

    vec_t vecs[N_VEC];
    int   cnt_before;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        i_rst_n     = 1'b0;
        i_req_valid = '0;
        i_req_addr  = '0;
        i_req_data  = '0;
        i_stall     = 1'b0;
        i_cnt_clr   = 1'b0;

        // round robin from reset: 0,1,2,3,0,1
        vecs[0]  = '{1'b1, 4'hF, 1'b0, 4'b0001};
        vecs[1]  = '{1'b0, 4'hF, 1'b0, 4'b0010};
        vecs[2]  = '{1'b0, 4'hF, 1'b0, 4'b0100};
        vecs[3]  = '{1'b0, 4'hF, 1'b0, 4'b1000};
        vecs[4]  = '{1'b0, 4'hF, 1'b0, 4'b0001};
        vecs[5]  = '{1'b0, 4'hF, 1'b0, 4'b0010};
        // stall for cycles 2..4, bubble at 5, resume with requester 2
        vecs[6]  = '{1'b1, 4'hF, 1'b0, 4'b0001};
        vecs[7]  = '{1'b0, 4'hF, 1'b0, 4'b0010};
        vecs[8]  = '{1'b0, 4'hF, 1'b1, 4'b0000};
        vecs[9]  = '{1'b0, 4'hF, 1'b1, 4'b0000};
        vecs[10] = '{1'b0, 4'hF, 1'b1, 4'b0000};
        vecs[11] = '{1'b0, 4'hF, 1'b0, 4'b0000};
        vecs[12] = '{1'b0, 4'hF, 1'b0, 4'b0100};
        vecs[13] = '{1'b0, 4'hF, 1'b0, 4'b1000};

        // reset state
        apply_reset();
        chk("rst_ready", o_req_ready, 0);
        chk("rst_wr_en", o_wr_en, 0);
        chk("rst_wr_sel", o_wr_sel, 0);
        chk("rst_wr_addr", o_wr_addr, 0);
        chk("rst_wr_data", o_wr_data, 0);
        chk("rst_wr_src", o_wr_src, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_count", o_wr_count, 0);

        // single request from requester 2
        set_req(2, 5'd7, 32'hDEADBEEF);
        i_req_valid = 4'b0100;
        do_cycle(4'b0100, 1'b1);
        chk("single_wr_en", o_wr_en, 1);
        chk("single_sel", o_wr_sel, 32'h0000_0080);
        chk("single_src", o_wr_src, 2);
        chk("single_data", o_wr_data, 32'hDEADBEEF);
        chk("single_count", o_wr_count, 1);
        i_req_valid = '0;
        do_cycle(4'b0000, 1'b1);

        // table: round robin and stall/bubble
        for (int i = 0; i < N_VEC; i++) begin
            if (vecs[i].do_reset) apply_reset();
            i_req_valid = vecs[i].valid;
            i_stall     = vecs[i].stall;
            for (int k = 0; k < N_REQ; k++) set_req(k, ADDR_W'(k + 1 + i), $urandom);
            do_cycle(vecs[i].exp_ready, 1'b1);
        end
        i_stall = 1'b0;

        // r0 write: accepted but not issued nor counted (pointer is at 3)
        cnt_before  = m_cnt;
        i_req_valid = 4'b0010;
        set_req(1, 5'd0, 32'h0000_1234);
        do_cycle(4'b0010, 1'b1);
        chk("r0_wr_en", o_wr_en, 0);
        chk("r0_sel", o_wr_sel, 0);
        chk("r0_count", o_wr_count, cnt_before);
        i_req_valid = '0;

        // counter saturation then clear-with-write
        apply_reset();
        i_req_valid = 4'b0001;
        for (int n = 0; n < 260; n++) begin
            set_req(0, 5'd5, $urandom);
            do_cycle(4'b0001, 1'b1);
        end
        chk("cnt_saturated", o_wr_count, 255);
        i_cnt_clr = 1'b1;
        do_cycle(4'b0001, 1'b1);
        chk("cnt_clr_wins", o_wr_count, 0);
        chk("cnt_clr_wr_en", o_wr_en, 1);
        i_cnt_clr   = 1'b0;
        i_req_valid = '0;

        // reset mid-stream drops the in-flight write asynchronously
        apply_reset();
        i_req_valid = 4'hF;
        for (int k = 0; k < N_REQ; k++) set_req(k, ADDR_W'(k + 10), $urandom);
        do_cycle(4'b0001, 1'b1);
        do_cycle(4'b0010, 1'b1);
        chk("pre_rst_wr_en", o_wr_en, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_wr_en", o_wr_en, 0);
        chk("async_rst_sel", o_wr_sel, 0);
        chk("async_rst_count", o_wr_count, 0);
        apply_reset();
        i_req_valid = 4'hF;
        for (int k = 0; k < N_REQ; k++) set_req(k, ADDR_W'(k + 20), $urandom);
        do_cycle(4'b0001, 1'b1);
        do_cycle(4'b0010, 1'b1);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            i_req_valid = N_REQ'($urandom_range(0, 15));
            for (int k = 0; k < N_REQ; k++) set_req(k, ADDR_W'($urandom_range(0, 31)), $urandom);
            i_stall   = ($urandom_range(0, 4) == 0);
            i_cnt_clr = ($urandom_range(0, 19) == 0);
            do_cycle('0, 1'b0);
        end
        i_req_valid = '0;
        i_stall     = 1'b0;
        i_cnt_clr   = 1'b0;
        do_cycle('0, 1'b0);
        chk("sb_drained", exp_q.size(), 0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
